// File: rtl/fc_layer_db.sv
// Double-buffered fully-connected layer front end: loads CIM rows, triggers compute, reads/accumulates columns.
// Optional build macro FC_LAYER_DB_SAT_EN: saturate o_func_data instead of truncating.
module fc_layer_db #(
  parameter int input_size           = 1210,
  parameter int output_size          = 10,
  parameter int xbar_size            = 128,
  parameter int datatype_size        = 2,
  parameter int output_datatype_size = 2,
  localparam int v_cim_tiles = (input_size + xbar_size - 1) / xbar_size,
  localparam int h_cim_tiles = (output_size * datatype_size + xbar_size - 1) / xbar_size
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               i_ibuf_we,
  input  logic [datatype_size-1:0]                           i_ibuf_wr_data,
  input  logic [$clog2(input_size)-1:0]                      i_ibuf_addr,
  input  logic                                               i_start,
  input  logic                                               i_cim_busy,
  input  logic                                               i_next_busy,
  input  logic [datatype_size*v_cim_tiles*h_cim_tiles-1:0]   i_data,
  output logic                                               o_busy,
  output logic                                               o_cim_we,
  output logic [$clog2(xbar_size)-1:0]                       o_cim_wr_addr,
  output logic [datatype_size*v_cim_tiles-1:0]               o_cim_data,
  output logic                                               o_cim_start,
  output logic [$clog2(xbar_size)-1:0]                       o_cim_rd_addr,
  output logic [output_datatype_size-1:0]                    o_func_data,
  output logic                                               o_func_valid,
  output logic                                               o_done
);
  // state  | meaning
  // IDLE   | waiting for i_start
  // LOAD   | streaming compute-bank rows into the crossbar
  // WAIT   | compute pulse issued, waiting for i_cim_busy to drop
  // READ   | issuing column reads, stalled by i_next_busy
  // DRAIN  | waiting for the last result to leave the pipeline
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_READ, S_DRAIN} state_t;

  localparam int addr_w = $clog2(input_size);
  localparam int xw     = $clog2(xbar_size);
  localparam int jw     = (output_size > 1) ? $clog2(output_size) : 1;
  localparam int hw     = (h_cim_tiles > 1) ? $clog2(h_cim_tiles) : 1;
  localparam int sw     = datatype_size + $clog2(v_cim_tiles) + 1;
  localparam logic [31:0] out_max = (32'd1 << output_datatype_size) - 32'd1;

  state_t state;
  logic wr_bank, wait_first;
  logic [xw-1:0] row;
  logic [jw-1:0] j;
  logic samp_v, samp_last;
  logic [hw-1:0] samp_h;

  logic [datatype_size-1:0] bank0 [input_size];
  logic [datatype_size-1:0] bank1 [input_size];

  always_ff @(posedge clk) begin
    if (i_ibuf_we && (32'(i_ibuf_addr) < input_size)) begin
      if (wr_bank) bank1[i_ibuf_addr] <= i_ibuf_wr_data;
      else         bank0[i_ibuf_addr] <= i_ibuf_wr_data;
    end
  end

  // Next row to present; in IDLE this is row 0 of the bank about to become the compute bank,
  // so a write landing on the start edge is forwarded.
  logic rd_sel;
  logic [xw-1:0] rd_row;
  logic [31:0] idx;
  logic [datatype_size*v_cim_tiles-1:0] row_nxt;

  always_comb begin
    rd_sel  = (state == S_IDLE) ? wr_bank : ~wr_bank;
    rd_row  = (state == S_IDLE) ? '0 : row + 1'b1;
    row_nxt = '0;
    idx     = '0;
    for (int t = 0; t < v_cim_tiles; t++) begin
      idx = 32'(t * xbar_size) + 32'(rd_row);
      if (idx < input_size) begin
        row_nxt[t*datatype_size +: datatype_size] = rd_sel ? bank1[idx[addr_w-1:0]] : bank0[idx[addr_w-1:0]];
        if ((state == S_IDLE) && i_ibuf_we && (idx == 32'(i_ibuf_addr)))
          row_nxt[t*datatype_size +: datatype_size] = i_ibuf_wr_data;
      end
    end
  end

  logic [31:0] col_cur, col_nxt;
  logic [hw-1:0] h_cur;
  logic [xw-1:0] rd_addr_nxt;

  assign col_cur     = 32'(j) * 32'(datatype_size);
  assign col_nxt     = col_cur + 32'(datatype_size);
  assign h_cur       = hw'(col_cur / 32'(xbar_size));
  assign rd_addr_nxt = xw'(col_nxt % 32'(xbar_size));

  logic [sw-1:0] sum;
  logic [output_datatype_size-1:0] func_nxt;

  always_comb begin
    sum = '0;
    for (int t = 0; t < v_cim_tiles; t++)
      sum = sum + sw'(i_data[(t*h_cim_tiles + int'(samp_h))*datatype_size +: datatype_size]);
`ifdef FC_LAYER_DB_SAT_EN
    func_nxt = (32'(sum) > out_max) ? output_datatype_size'(out_max) : output_datatype_size'(sum);
`else
    func_nxt = output_datatype_size'(sum);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wr_bank       <= 1'b0;
      wait_first    <= 1'b0;
      row           <= '0;
      j             <= '0;
      samp_v        <= 1'b0;
      samp_last     <= 1'b0;
      samp_h        <= '0;
      o_busy        <= 1'b0;
      o_cim_we      <= 1'b0;
      o_cim_wr_addr <= '0;
      o_cim_data    <= '0;
      o_cim_start   <= 1'b0;
      o_cim_rd_addr <= '0;
      o_func_data   <= '0;
      o_func_valid  <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_cim_start  <= 1'b0;
      samp_v       <= 1'b0;
      samp_last    <= 1'b0;
      o_func_valid <= samp_v;
      o_done       <= samp_v && samp_last;
      if (samp_v) o_func_data <= func_nxt;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            wr_bank       <= ~wr_bank;
            state         <= S_LOAD;
            row           <= '0;
            o_busy        <= 1'b1;
            o_cim_we      <= 1'b1;
            o_cim_wr_addr <= '0;
            o_cim_data    <= row_nxt;
          end
        end
        S_LOAD: begin
          if (row == xw'(xbar_size - 1)) begin
            o_cim_we    <= 1'b0;
            o_cim_start <= 1'b1;
            wait_first  <= 1'b1;
            state       <= S_WAIT;
          end else begin
            row           <= row + 1'b1;
            o_cim_wr_addr <= row + 1'b1;
            o_cim_data    <= row_nxt;
          end
        end
        // the CIM only raises busy after seeing the start pulse
        S_WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!i_cim_busy) begin
            state         <= S_READ;
            j             <= '0;
            o_cim_rd_addr <= '0;
          end
        end
        S_READ: begin
          if (!i_next_busy) begin
            samp_v    <= 1'b1;
            samp_h    <= h_cur;
            samp_last <= (j == jw'(output_size - 1));
            if (j == jw'(output_size - 1)) begin
              state <= S_DRAIN;
            end else begin
              j             <= j + 1'b1;
              o_cim_rd_addr <= rd_addr_nxt;
            end
          end
        end
        S_DRAIN: begin
          if (o_done) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
